drm_wr_gen: RTL and testbench
=============================

DRM_WR_GEN -- requirements
Module: drm_wr_gen

Interface
REQ-001 SHALL have parameter WR_ADDR_WIDTH, default 12, the SDPRAM write-address width.
REQ-002 SHALL have parameter WR_DATA_WIDTH, default 8, the SDPRAM write-data width.
REQ-003 SHALL have port wr_clk, input, 1, write-side clock; all logic is on the rising edge.
REQ-004 SHALL have port tb_wr_rst, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, WR_ADDR_WIDTH, first write address.
REQ-007 SHALL have port length, input, WR_ADDR_WIDTH+1, number of words to write; range 0..2^WR_ADDR_WIDTH.
REQ-008 SHALL have port seed, input, WR_DATA_WIDTH, first data word.
REQ-009 SHALL have port mode, input, 2, data pattern select.
REQ-010 SHALL have port hold, input, 1, pause; suppresses writes while high.
REQ-011 SHALL have ports wr_en (1), wr_addr (WR_ADDR_WIDTH) and wr_data (WR_DATA_WIDTH), all outputs, which drive the SDPRAM write port directly.
REQ-012 SHALL have port busy, output, 1, high in RUN and DONE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port wr_count, output, WR_ADDR_WIDTH+1, number of words written in the current or last run.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-016 On IDLE with start=1, the block SHALL capture base_addr, length, seed and mode, clear wr_count, and enter RUN (length>0) or DONE (length=0).
REQ-017 SHALL assert the first wr_en in the cycle after start is accepted, with wr_addr=base_addr and wr_data=seed.
REQ-018 In RUN with hold=0, the block SHALL issue one write per cycle; wr_addr SHALL increment by 1 modulo 2^WR_ADDR_WIDTH, and wr_count SHALL increment by 1.
REQ-019 In RUN with hold=1, wr_en SHALL be 0, and the address, data and count SHALL be frozen.
REQ-020 Data pattern by mode SHALL be: 0 = decrement by 1 per write (wraps); 1 = increment by 1 (wraps); 2 = constant seed; 3 = rotate left by 1 per write.
REQ-021 After the write that makes wr_count equal length, the block SHALL enter DONE, deassert wr_en, and assert done for exactly one cycle, then return to IDLE.
REQ-022 length = 2^WR_ADDR_WIDTH SHALL write every address exactly once, wrapping past the top address back toward base_addr.
REQ-023 start SHALL be ignored in RUN and DONE; hold SHALL be ignored outside RUN.
REQ-024 If hold=1 coincides with the would-be final write, the final write SHALL be deferred until hold=0.
REQ-025 length=0 SHALL produce no wr_en, one done pulse two cycles after start, and wr_count=0.

Reset
REQ-026 tb_wr_rst=1 SHALL force state IDLE and drive wr_en, wr_addr, wr_data, busy, done and wr_count to 0 immediately, including mid-run.
REQ-027 After reset release, the block SHALL accept start on the first rising edge.

Configuration
REQ-028 With macro DRM_WR_GEN_CHKSUM_EN defined, the block SHALL add output chksum (WR_DATA_WIDTH bits) holding the XOR of all wr_data values written in the run.
REQ-029 chksum SHALL be cleared on start acceptance, reset to 0, and be stable from the done pulse until the next start.
REQ-030 Without DRM_WR_GEN_CHKSUM_EN, the chksum port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 Package drm_wr_gen_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the mode constants (MODE_DEC=0, MODE_INC=1, MODE_CONST=2, MODE_ROTL=3).
REQ-032 The next-data computation SHALL be a combinational sub-module drm_wr_pat (inputs: mode, cur_data; output: next_data).

Verification
REQ-033 Scenario 1: base=0, length=4096, seed=8'hFF, mode=0 -> 4096 consecutive wr_en, addr 0..4095, data FF,FE,...,00,FF,... wrapping; done one cycle after addr 4095; wr_count=4096.
REQ-034 Scenario 2: base=12'hFFE, length=4, seed=8'h10, mode=1 -> addr FFE,FFF,000,001 with data 10,11,12,13.
REQ-035 Scenario 3: mode=3, seed=8'h81, length=3 -> data 81,03,06; with DRM_WR_GEN_CHKSUM_EN, chksum=8'h84.
REQ-036 Scenario 4: length=8, hold high for writes 3-5 and on the last write -> exactly 8 writes, gaps with no wr_en, no address skipped, done after the eighth write.
REQ-037 Scenario 5: length=0 -> no writes, done 2 cycles after start; start pulsed in RUN -> ignored.
REQ-038 Scenario 6: tb_wr_rst asserted mid-run at write 100 -> all outputs 0 asynchronously; a new start after release begins from the new base_addr.

Source files
------------

// File: rtl/drm_wr_gen_pkg.sv
// Shared types for the SDPRAM write-pattern generator: FSM state encoding and
// data-pattern mode codes.
package drm_wr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_DEC   = 2'd0;
    localparam logic [1:0] MODE_INC   = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_ROTL  = 2'd3;

endpackage

// File: rtl/drm_wr_gen_pat.sv
// Next-data generator for drm_wr_gen: derives the following write word from the
// current one according to the selected pattern mode. Purely combinational.
module drm_wr_pat
    import drm_wr_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] cur_data,
    output logic [WIDTH-1:0] next_data
);

    always_comb begin
        next_data = cur_data;
        case (mode)
            MODE_DEC:   next_data = cur_data - WIDTH'(1);
            MODE_INC:   next_data = cur_data + WIDTH'(1);
            MODE_CONST: next_data = cur_data;
            MODE_ROTL:  next_data = {cur_data[WIDTH-2:0], cur_data[WIDTH-1]};
        endcase
    end

endmodule

// File: rtl/drm_wr_gen.sv
// SDPRAM write-pattern generator: writes `length` words from base_addr with a
// selectable data pattern. Optional checksum output under DRM_WR_GEN_CHKSUM_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold results of the last run
// RUN   | issuing one write per cycle unless paused by hold
// DONE  | run complete; done pulses once (zero-length runs stay two cycles)
module drm_wr_gen
    import drm_wr_gen_pkg::*;
#(
    parameter int WR_ADDR_WIDTH = 12,
    parameter int WR_DATA_WIDTH = 8
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic [WR_ADDR_WIDTH-1:0] base_addr,
    input  logic [WR_ADDR_WIDTH:0]   length,
    input  logic [WR_DATA_WIDTH-1:0] seed,
    input  logic [1:0]               mode,
    input  logic                     hold,
`ifdef DRM_WR_GEN_CHKSUM_EN
    output logic [WR_DATA_WIDTH-1:0] chksum,
`endif
    output logic                     wr_en,
    output logic [WR_ADDR_WIDTH-1:0] wr_addr,
    output logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [WR_ADDR_WIDTH:0]   wr_count
);

    localparam int AW = WR_ADDR_WIDTH;
    localparam int DW = WR_DATA_WIDTH;
    localparam int CW = WR_ADDR_WIDTH + 1;

    state_t          state_q, state_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   next_data;
    logic            last_wr;

    drm_wr_pat #(
        .WIDTH (DW)
    ) u_pat (
        .mode      (mode_q),
        .cur_data  (data_q),
        .next_data (next_data)
    );

    // rem_q counts down words still to be written; the cycle carrying the
    // word with rem_q==1 is the terminal write.
    assign last_wr = wr_en_q && (rem_q == CW'(1));

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_DEC;
        end else begin
            state_q <= state_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data registers always show the pending write, so a pause simply
    // drops wr_en and the same word goes out once hold clears.
    always_comb begin
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    data_d  = seed;
                    mode_d  = mode;
                    cnt_d   = '0;
                    rem_d   = length;
                    wr_en_d = (length != '0);
                end
            end
            RUN: begin
                if (wr_en_q) begin
                    cnt_d = cnt_q + CW'(1);
                    rem_d = rem_q - CW'(1);
                end
                if (last_wr) begin
                    done_d = 1'b1;
                end else begin
                    if (wr_en_q) begin
                        addr_d = addr_q + AW'(1);
                        data_d = next_data;
                    end
                    wr_en_d = !hold;
                end
            end
            DONE: begin
                done_d = !done_q;
            end
            default: ;
        endcase
    end

    assign busy_d = (state_d != IDLE);

`ifdef DRM_WR_GEN_CHKSUM_EN
    logic [DW-1:0] chk_q, chk_d;

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    always_comb begin
        chk_d = chk_q;
        if (state_q == IDLE && start) begin
            chk_d = '0;
        end else if (state_q == RUN && wr_en_q) begin
            chk_d = chk_q ^ data_q;
        end
    end

    assign chksum = chk_q;
`endif

    assign wr_en    = wr_en_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_drm_wr_gen.sv
// Directed self-checking bench for drm_wr_gen; chksum checks are compiled in
// only when DRM_WR_GEN_CHKSUM_EN is defined.
module tb_drm_wr_gen;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          wr_clk = 1'b0;
    logic          tb_wr_rst = 1'b1;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] seed = '0;
    logic [1:0]    mode = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   wr_count;
`ifdef DRM_WR_GEN_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    always #5 wr_clk = ~wr_clk;

    drm_wr_gen #(
        .WR_ADDR_WIDTH (AW),
        .WR_DATA_WIDTH (DW)
    ) dut (
        .wr_clk    (wr_clk),
        .tb_wr_rst (tb_wr_rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .seed      (seed),
        .mode      (mode),
        .hold      (hold),
`ifdef DRM_WR_GEN_CHKSUM_EN
        .chksum    (chksum),
`endif
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count)
    );

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a run request for one edge; returns in the first cycle after acceptance.
    task automatic start_run(input int b, input int l, input int s, input int m);
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        seed      = DW'(s);
        mode      = 2'(m);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int s2_addr [4] = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
        int s2_data [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
        int s3_data [3] = '{32'h81, 32'h03, 32'h06};
        int s4_hold [13] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0, 1};
        int s4_en   [13] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1};
        int s4_off  [13] = '{0, 1, 2, 2, 2, 3, 3, 4, 5, 6, 7, 7, 7};

        // Reset state
        tick(); tick(); tick();
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        tb_wr_rst = 1'b0;

        // Scenario 2: address wrap past top
        start_run(12'hFFE, 4, 8'h10, 1);
        check("s2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("s2_en", 32'(wr_en), 32'd1);
            check("s2_addr", 32'(wr_addr), 32'(s2_addr[i]));
            check("s2_data", 32'(wr_data), 32'(s2_data[i]));
            check("s2_count", 32'(wr_count), 32'(i));
            tick();
        end
        check("s2_done", 32'(done), 32'd1);
        check("s2_en_off", 32'(wr_en), 32'd0);
        check("s2_count_end", 32'(wr_count), 32'd4);
        tick();
        check("s2_done_pulse", 32'(done), 32'd0);
        check("s2_idle_busy", 32'(busy), 32'd0);

        // Scenario 3: rotate-left pattern, hold high at acceptance is ignored
        hold = 1'b1;
        start_run(5, 3, 8'h81, 3);
        hold = 1'b0;
`ifdef DRM_WR_GEN_CHKSUM_EN
        check("s3_chk_clear", 32'(chksum), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            check("s3_en", 32'(wr_en), 32'd1);
            check("s3_data", 32'(wr_data), 32'(s3_data[i]));
            tick();
        end
        check("s3_done", 32'(done), 32'd1);
`ifdef DRM_WR_GEN_CHKSUM_EN
        check("s3_chksum", 32'(chksum), 32'h84);
`endif
        tick();
`ifdef DRM_WR_GEN_CHKSUM_EN
        check("s3_chksum_stable", 32'(chksum), 32'h84);
`endif

        // Scenario 4: hold gaps, including over the final write
        start_run(12'h020, 8, 0, 1);
        for (int c = 0; c < 13; c++) begin
            check("s4_en", 32'(wr_en), 32'(s4_en[c]));
            check("s4_addr", 32'(wr_addr), 32'(12'h020 + s4_off[c]));
            check("s4_data", 32'(wr_data), 32'(s4_off[c]));
            check("s4_count", 32'(wr_count), 32'(s4_off[c]));
            check("s4_done_early", 32'(done), 32'd0);
            hold = s4_hold[c][0];
            tick();
        end
        hold = 1'b0;
        check("s4_done", 32'(done), 32'd1);
        check("s4_en_off", 32'(wr_en), 32'd0);
        check("s4_count_end", 32'(wr_count), 32'd8);
        tick();

        // Scenario 5: zero length, then start ignored in RUN and DONE
        start_run(12'h050, 0, 8'h33, 1);
        check("s5_busy", 32'(busy), 32'd1);
        check("s5_en_c1", 32'(wr_en), 32'd0);
        check("s5_done_c1", 32'(done), 32'd0);
        tick();
        check("s5_en_c2", 32'(wr_en), 32'd0);
        check("s5_done_c2", 32'(done), 32'd1);
        check("s5_count", 32'(wr_count), 32'd0);
        tick();
        check("s5_done_c3", 32'(done), 32'd0);
        check("s5_idle", 32'(busy), 32'd0);
        start_run(12'h100, 3, 8'h5A, 2);
        check("s5b_addr0", 32'(wr_addr), 32'h100);
        base_addr = 12'h500;
        length    = 13'd9;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("s5b_addr1", 32'(wr_addr), 32'h101);
        check("s5b_data1", 32'(wr_data), 32'h5A);
        tick();
        check("s5b_addr2", 32'(wr_addr), 32'h102);
        check("s5b_data2", 32'(wr_data), 32'h5A);
        tick();
        check("s5b_done", 32'(done), 32'd1);
        check("s5b_count", 32'(wr_count), 32'd3);
        start = 1'b1;
        tick();
        check("s5b_idle", 32'(busy), 32'd0);
        check("s5b_no_wr", 32'(wr_en), 32'd0);
        start = 1'b0;
        tick();

        // Scenario 1: full 4096-word sweep with decrementing data
        errs = 0;
        start_run(0, 4096, 8'hFF, 0);
        for (int i = 0; i < 4096; i++) begin
            if (!(wr_en === 1'b1 && wr_addr === AW'(i) &&
                  wr_data === DW'(255 - i) && wr_count === (AW+1)'(i)))
                errs++;
            if (done !== 1'b0)
                errs++;
            tick();
        end
        check("s1_stream_errs", 32'(errs), 32'd0);
        check("s1_done", 32'(done), 32'd1);
        check("s1_en_off", 32'(wr_en), 32'd0);
        check("s1_count", 32'(wr_count), 32'd4096);
        tick();
        check("s1_idle", 32'(busy), 32'd0);
        check("s1_count_hold", 32'(wr_count), 32'd4096);

        // Scenario 6: asynchronous reset mid-run, restart on first edge after release
        start_run(0, 200, 0, 1);
        for (int i = 0; i < 100; i++) tick();
        check("s6_addr100", 32'(wr_addr), 32'd100);
        check("s6_count100", 32'(wr_count), 32'd100);
        #1;
        tb_wr_rst = 1'b1;
        #1;
        check("s6_rst_en", 32'(wr_en), 32'd0);
        check("s6_rst_addr", 32'(wr_addr), 32'd0);
        check("s6_rst_data", 32'(wr_data), 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        check("s6_rst_done", 32'(done), 32'd0);
        check("s6_rst_count", 32'(wr_count), 32'd0);
`ifdef DRM_WR_GEN_CHKSUM_EN
        check("s6_rst_chksum", 32'(chksum), 32'd0);
`endif
        tick(); tick();
        tb_wr_rst = 1'b0;
        start_run(12'h300, 2, 8'h07, 1);
        check("s6_new_en", 32'(wr_en), 32'd1);
        check("s6_new_addr", 32'(wr_addr), 32'h300);
        check("s6_new_data", 32'(wr_data), 32'h07);
        check("s6_new_count", 32'(wr_count), 32'd0);
        tick();
        check("s6_addr2", 32'(wr_addr), 32'h301);
        check("s6_data2", 32'(wr_data), 32'h08);
        tick();
        check("s6_done", 32'(done), 32'd1);
        check("s6_count_end", 32'(wr_count), 32'd2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
